// File: rtl/lsu_mem_access_pkg.sv
// lsu_mem_access_pkg
//   Shared constants for the load/store unit: decoder load/store codes,
//   access sizes, FSM state encodings, the registered bus request record,
//   and small decode helpers used by the top and the load extender.
package lsu_mem_access_pkg;

    // Decoder load codes (011 and 110 are illegal)
    localparam logic [2:0] LD_LB   = 3'b000;
    localparam logic [2:0] LD_LH   = 3'b001;
    localparam logic [2:0] LD_LW   = 3'b010;
    localparam logic [2:0] LD_LBU  = 3'b100;
    localparam logic [2:0] LD_LHU  = 3'b101;
    localparam logic [2:0] LD_NONE = 3'b111;

    // Decoder store codes
    localparam logic [1:0] ST_SB   = 2'b00;
    localparam logic [1:0] ST_SH   = 2'b01;
    localparam logic [1:0] ST_SW   = 2'b10;
    localparam logic [1:0] ST_NONE = 2'b11;

    // Access size; both code sets encode size in their low two bits
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // FSM states
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_req_t;

    function automatic logic ld_legal(input logic [2:0] code);
        logic ok;
        ok = 1'b0;
        case (code)
            LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU: ok = 1'b1;
            default:                             ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (sz)
            SZ_B:    ok = 1'b1;
            SZ_H:    ok = ~off[0];
            SZ_W:    ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// lsu_load_ext
//   Combinational load-data formatter: picks the byte/half lane addressed by
//   the latched offset and sign- or zero-extends it to 32 bits.
// Ports
//   rdata     in  32  raw word from the data bus
//   offset    in  2   latched addr[1:0] of the access
//   load_code in  3   latched decoder load code
//   data      out 32  extended load result
module lsu_load_ext
    import lsu_mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  load_code,
    output logic [31:0] data
);

    logic [3:0][7:0] lanes;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;

    assign lanes    = rdata;
    assign byte_sel = lanes[offset];
    // Halfwords are aligned, so only offset[1] picks the half
    assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        data = rdata;
        case (load_code)
            LD_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  data = {24'd0, byte_sel};
            LD_LH:   data = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_access.sv
// lsu_mem_access
//   Load/store unit behind the control decoder of the single-cycle core.
//   Runs one req/ack transaction per memory instruction (IDLE -> WAIT -> DONE),
//   lane-replicates store data, generates byte enables, extends load data and
//   holds the PC via a combinational stall until the access finishes.
// Ports
//   clk, rst                      core clock, synchronous active-high reset
//   load_code/store_code          decoder codes (store wins if both valid)
//   addr, data_rs2                effective address, store source
//   stall                         combinational PC/regfile hold
//   rd_data, rd_valid             registered load result and its pulse
//   misalign, timeout             one-cycle error pulses
//   mem_req/we/addr/be/wdata      registered data-bus request
//   mem_ack, mem_rdata            data-bus completion and read data
module lsu_mem_access
    import lsu_mem_access_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  load_code,
    input  logic [1:0]  store_code,
    input  logic [31:0] addr,
    input  logic [31:0] data_rs2,
    output logic        stall,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        misalign,
    output logic        timeout,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_WAIT);

    logic [1:0]  state;
    logic [7:0]  wait_cnt;
    logic [1:0]  off_q;
    logic [2:0]  ld_code_q;
    logic        is_load_q;
    mem_req_t    req_q;
    mem_req_t    req_nxt;

    logic        st_sel;
    logic        ld_sel;
    logic        ld_bad;
    logic [1:0]  sz;
    logic        aligned;
    logic        start;
    logic        reject;
    logic [31:0] ext_data;

    // Decode: a valid store overrides whatever the load field says
    assign st_sel  = (store_code != ST_NONE);
    assign ld_sel  = ~st_sel & ld_legal(load_code);
    assign ld_bad  = ~st_sel & (load_code != LD_NONE) & ~ld_legal(load_code);
    assign sz      = st_sel ? store_code : load_code[1:0];
    assign aligned = is_aligned(sz, addr[1:0]);

    assign start  = (state == S_IDLE) & (st_sel | ld_sel) & aligned;
    assign reject = (state == S_IDLE) & (ld_bad | ((st_sel | ld_sel) & ~aligned));
    assign stall  = start | (state == S_WAIT);

    always_comb begin
        req_nxt       = '0;
        req_nxt.req   = 1'b1;
        req_nxt.we    = st_sel;
        req_nxt.addr  = {addr[31:2], 2'b00};
        req_nxt.be    = 4'b1111;
        if (st_sel) begin
            case (store_code)
                ST_SB: begin
                    req_nxt.be    = 4'b0001 << addr[1:0];
                    req_nxt.wdata = {4{data_rs2[7:0]}};
                end
                ST_SH: begin
                    req_nxt.be    = 4'b0011 << {addr[1], 1'b0};
                    req_nxt.wdata = {2{data_rs2[15:0]}};
                end
                default: req_nxt.wdata = data_rs2;
            endcase
        end
    end

    lsu_load_ext u_load_ext (
        .rdata     (mem_rdata),
        .offset    (off_q),
        .load_code (ld_code_q),
        .data      (ext_data)
    );

    // wait_cnt holds the 1-based index of the current WAIT cycle, so the
    // abort fires at the end of the MAX_WAIT-th cycle without an ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wait_cnt  <= 8'd0;
            off_q     <= 2'b00;
            ld_code_q <= 3'b000;
            is_load_q <= 1'b0;
            req_q     <= '0;
            rd_data   <= 32'd0;
            rd_valid  <= 1'b0;
            misalign  <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            misalign <= 1'b0;
            timeout  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_WAIT;
                        req_q     <= req_nxt;
                        off_q     <= addr[1:0];
                        ld_code_q <= load_code;
                        is_load_q <= ~st_sel;
                        wait_cnt  <= 8'd1;
                    end else if (reject) begin
                        misalign <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        state     <= S_DONE;
                        req_q.req <= 1'b0;
                        wait_cnt  <= 8'd0;
                        if (is_load_q) begin
                            rd_data  <= ext_data;
                            rd_valid <= 1'b1;
                        end
                    end else if (wait_cnt == MAX_CNT) begin
                        state     <= S_DONE;
                        req_q.req <= 1'b0;
                        wait_cnt  <= 8'd0;
                        rd_data   <= 32'd0;
                        timeout   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mem_req   = req_q.req;
    assign mem_we    = req_q.we;
    assign mem_addr  = req_q.addr;
    assign mem_be    = req_q.be;
    assign mem_wdata = req_q.wdata;

endmodule
